// File: rtl/ex_mem_pipe_pkg.sv
// Shared types for the EX->MEM pipeline stage: the carried entry record,
// the default destination-register width and the skid-buffer state encoding.
package ex_mem_pipe_pkg;

    // Default destination-register index width. The entry record carries
    // exactly this many Rd bits, so RD_W on the stage must not exceed it.
    localparam int EXMEM_RD_W = 5;

    // Everything the execute stage hands to memaccess, kept as one record.
    typedef struct packed {
        logic [31:0]           ALU_result;
        logic [31:0]           Rdata2;
        logic [31:0]           PC;
        logic [31:0]           imm32;
        logic [31:0]           jump_target_PC;
        logic [EXMEM_RD_W-1:0] Rd;
        logic                  jump_flag;
        logic                  branch_op;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  reg_wr;
    } entry_t;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // A jump always redirects; a branch redirects when the ALU flags it.
    function automatic logic is_taken(entry_t e);
        return e.jump_flag | (e.branch_op & e.ALU_result[0]);
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// Handshake and payload bundle between execute, the EX->MEM stage and memaccess.
// master: the surrounding pipeline (execute producer + memaccess consumer).
// slave : the EX->MEM stage itself.
interface ex_mem_pipe_if #(
    parameter int RD_W = ex_mem_pipe_pkg::EXMEM_RD_W
);
    // execute side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     ALU_result;
    logic [31:0]     Rdata2;
    logic [31:0]     PC;
    logic [31:0]     imm32;
    logic [31:0]     jump_target_PC;
    logic [RD_W-1:0] Rd;
    logic            jump_flag;
    logic            branch_op;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
    logic            flush;

    // memaccess side
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_ALU_result;
    logic [31:0]     out_Rdata2;
    logic [31:0]     out_PC;
    logic [31:0]     out_imm32;
    logic [31:0]     out_jump_target_PC;
    logic [RD_W-1:0] out_Rd;
    logic            out_jump_flag;
    logic            out_branch_op;
    logic            out_mem_rd;
    logic            out_mem_wr;
    logic            out_reg_wr;

    // fetch redirect
    logic            redirect_valid;
    logic [31:0]     redirect_PC;

    modport master (
        output in_valid, ALU_result, Rdata2, PC, imm32, jump_target_PC, Rd,
               jump_flag, branch_op, mem_rd, mem_wr, reg_wr, flush, out_ready,
        input  in_ready, out_valid, out_ALU_result, out_Rdata2, out_PC, out_imm32,
               out_jump_target_PC, out_Rd, out_jump_flag, out_branch_op,
               out_mem_rd, out_mem_wr, out_reg_wr, redirect_valid, redirect_PC
    );

    modport slave (
        input  in_valid, ALU_result, Rdata2, PC, imm32, jump_target_PC, Rd,
               jump_flag, branch_op, mem_rd, mem_wr, reg_wr, flush, out_ready,
        output in_ready, out_valid, out_ALU_result, out_Rdata2, out_PC, out_imm32,
               out_jump_target_PC, out_Rd, out_jump_flag, out_branch_op,
               out_mem_rd, out_mem_wr, out_reg_wr, redirect_valid, redirect_PC
    );

endinterface

// File: rtl/ex_mem_pipe_slot.sv
// exmem_slot: one entry-wide payload register with a load enable.
// Cleared by reset so the payload reads as zero while the stage is held in reset.
module exmem_slot
    import ex_mem_pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   ld_i,
    input  entry_t d_i,
    output entry_t q_o
);

    entry_t data_q;

    // Capture a new entry only when loaded; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline stage with valid/ready flow control and a
// one-cycle fetch-redirect pulse for taken jumps/branches.
// Build option EXMEM_SKID_EN: two-entry skid buffer with a registered in_ready.
// Without it a single register is used and in_ready is combinational
// (~out_valid | out_ready), which still sustains one entry per cycle.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int RD_W = EXMEM_RD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_pipe_if.slave bus
);

    entry_t      in_ent;
    entry_t      head;
    logic        in_rdy;
    logic        out_vld;
    logic        accept;
    logic        pop;
    logic        redir_vld_q, redir_vld_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    // Pack the execute outputs into one record.
    always_comb begin
        in_ent                = '0;
        in_ent.ALU_result     = bus.ALU_result;
        in_ent.Rdata2         = bus.Rdata2;
        in_ent.PC             = bus.PC;
        in_ent.imm32          = bus.imm32;
        in_ent.jump_target_PC = bus.jump_target_PC;
        in_ent.Rd             = EXMEM_RD_W'(bus.Rd);
        in_ent.jump_flag      = bus.jump_flag;
        in_ent.branch_op      = bus.branch_op;
        in_ent.mem_rd         = bus.mem_rd;
        in_ent.mem_wr         = bus.mem_wr;
        in_ent.reg_wr         = bus.reg_wr;
    end

    assign accept = bus.in_valid & in_rdy;
    assign pop    = out_vld & bus.out_ready;

    // A taken entry accepted this cycle raises redirect next cycle unless a
    // flush kills it; the target is held between pulses.
    always_comb begin
        redir_vld_d = accept & is_taken(in_ent) & ~bus.flush;
        redir_pc_d  = redir_vld_d ? in_ent.jump_target_PC : redir_pc_q;
    end

    // Redirect pulse and target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

`ifdef EXMEM_SKID_EN

    skid_state_e state_q, state_d;
    entry_t      tail;
    entry_t      head_d;
    logic        ld_head;
    logic        ld_tail;

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and slot steering. The head slot always feeds memaccess;
    // the tail only fills when the head is stalled, and moves up on pop.
    always_comb begin
        state_d = state_q;
        ld_head = 1'b0;
        ld_tail = 1'b0;
        head_d  = in_ent;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    ld_head = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    ld_head = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    ld_tail = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    ld_head = 1'b1;
                    head_d  = tail;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any same-cycle accept; slot contents become don't-care.
        if (bus.flush) begin
            state_d = EMPTY;
        end
    end

    exmem_slot u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (ld_head),
        .d_i   (head_d),
        .q_o   (head)
    );

    exmem_slot u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (ld_tail),
        .d_i   (in_ent),
        .q_o   (tail)
    );

    assign out_vld = (state_q != EMPTY);
    assign in_rdy  = (state_q != FULL);

`else

    logic valid_q, valid_d;

    // Single-entry occupancy: flush beats accept, accept beats pop.
    always_comb begin
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    exmem_slot u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (accept),
        .d_i   (in_ent),
        .q_o   (head)
    );

    assign out_vld = valid_q;
    assign in_rdy  = ~valid_q | bus.out_ready;

`endif

    assign bus.in_ready           = in_rdy;
    assign bus.out_valid          = out_vld;
    assign bus.out_ALU_result     = head.ALU_result;
    assign bus.out_Rdata2         = head.Rdata2;
    assign bus.out_PC             = head.PC;
    assign bus.out_imm32          = head.imm32;
    assign bus.out_jump_target_PC = head.jump_target_PC;
    assign bus.out_Rd             = RD_W'(head.Rd);
    assign bus.out_jump_flag      = head.jump_flag;
    assign bus.out_branch_op      = head.branch_op;
    assign bus.out_mem_rd         = head.mem_rd;
    assign bus.out_mem_wr         = head.mem_wr;
    assign bus.out_reg_wr         = head.reg_wr;
    assign bus.redirect_valid     = redir_vld_q;
    assign bus.redirect_PC        = redir_pc_q;

endmodule
